// File: rtl/iob_aoi_sweep.sv
// iob_aoi_sweep: exhaustive self-checking sweep for an AND-OR-INVERT cell.
// Walks all 16 {d,c,b,a} patterns through the external AOI. Each pattern is
// held for SETTLE idle cycles and then y_i is compared against
// ~((a&b)|(c&d)). The block counts mismatching patterns and records the
// first failing index.
module iob_aoi_sweep #(
    parameter int unsigned W      = 1,
    parameter int unsigned SETTLE = 1
) (
    input  logic         clk_i,
    input  logic         cke_i,
    input  logic         arst_i,
    input  logic         start_i,
    output logic [W-1:0] a_o,
    output logic [W-1:0] b_o,
    output logic [W-1:0] c_o,
    output logic [W-1:0] d_o,
    input  logic [W-1:0] y_i,
    output logic         busy_o,
    output logic         done_o,
    output logic         pass_o,
    output logic [4:0]   err_cnt_o,
    output logic [3:0]   first_err_o,
    output logic         first_err_vld_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } state_t;

    localparam logic [3:0] SETTLE_LD = 4'(SETTLE);

    state_t       state;
    logic [3:0]   idx;
    logic [3:0]   pattern;
    logic [3:0]   settle_cnt;
    logic         exp_bit;
    logic [W-1:0] exp_y;
    logic         mismatch;

    // Every lane carries the same pattern bit; the pattern register is the only source.
    assign a_o = {W{pattern[0]}};
    assign b_o = {W{pattern[1]}};
    assign c_o = {W{pattern[2]}};
    assign d_o = {W{pattern[3]}};

    // pass is only meaningful once the sweep has finished
    assign pass_o = done_o & (err_cnt_o == 5'd0);

    // Reference AOI response for the current pattern; any differing lane flags the pattern.
    always_comb begin
        exp_bit  = ~((pattern[0] & pattern[1]) | (pattern[2] & pattern[3]));
        exp_y    = {W{exp_bit}};
        mismatch = (y_i != exp_y);
    end

    // Sweep sequencer with registered status and result outputs.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state           <= S_IDLE;
            idx             <= '0;
            pattern         <= '0;
            settle_cnt      <= '0;
            err_cnt_o       <= '0;
            first_err_o     <= '0;
            first_err_vld_o <= 1'b0;
            busy_o          <= 1'b0;
            done_o          <= 1'b0;
        end else if (cke_i) begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start_i) begin
                        state           <= S_DRIVE;
                        idx             <= '0;
                        pattern         <= '0;
                        err_cnt_o       <= '0;
                        first_err_o     <= '0;
                        first_err_vld_o <= 1'b0;
                        busy_o          <= 1'b1;
                        done_o          <= 1'b0;
                    end
                end
                S_DRIVE: begin
                    settle_cnt <= SETTLE_LD;
                    if (SETTLE != 0) begin
                        state <= S_SETTLE;
                    end else begin
                        state <= S_CHECK;
                    end
                end
                S_SETTLE: begin
                    settle_cnt <= settle_cnt - 4'd1;
                    if (settle_cnt == 4'd1) begin
                        state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (mismatch) begin
                        err_cnt_o <= err_cnt_o + 5'd1;
                        if (!first_err_vld_o) begin
                            first_err_o     <= idx;
                            first_err_vld_o <= 1'b1;
                        end
                    end
                    if (idx == 4'd15) begin
                        // pattern is left at 15 so the outputs hold the last vector in DONE
                        state  <= S_DONE;
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                    end else begin
                        idx     <= idx + 4'd1;
                        pattern <= idx + 4'd1;
                        state   <= S_DRIVE;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    busy_o <= 1'b0;
                    done_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iob_aoi_sweep.sv
// Testbench for iob_aoi_sweep: four instances (SETTLE 0/1/3, W=1, plus W=4)
// driven by an external AOI model with selectable faults. The driver pushes
// hand-computed results into a scoreboard; the monitor checks them when done_o rises.
module tb_iob_aoi_sweep;

    localparam int NDUT = 4;

    typedef struct {
        int          g;
        int unsigned done_cyc;
        logic [4:0]  err;
        logic [3:0]  ferr;
        logic        vld;
        logic        pass;
        logic [3:0]  ones;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                      cke;
    logic                      arst;
    logic [NDUT-1:0]           start;
    logic [NDUT-1:0][3:0]      a, b, c, d, y;
    logic [NDUT-1:0]           busy, done, pass, vld;
    logic [NDUT-1:0][4:0]      errc;
    logic [NDUT-1:0][3:0]      ferr;

    logic [1:0]  y_mode;      // 0 real AOI, 1 tied 0, 2 tied 1, 3 missing invert
    int          stuck_lane;  // lane of the W=4 instance forced to stuck_val, -1 none
    logic        stuck_val;

    int unsigned cyc;
    int          checks;
    int          failures;
    exp_t        sbq[$];
    logic [3:0]  patq[$];
    bit          chk_pat;
    int unsigned st_cyc;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int unsigned GW = (g == 3) ? 4 : 1;
        localparam int unsigned GS = (g == 0) ? 0 : ((g == 2) ? 3 : 1);
        logic [GW-1:0] la, lb, lc, ld, ly;
        iob_aoi_sweep #(.W(GW), .SETTLE(GS)) u_dut (
            .clk_i          (clk),
            .cke_i          (cke),
            .arst_i         (arst),
            .start_i        (start[g]),
            .a_o            (la),
            .b_o            (lb),
            .c_o            (lc),
            .d_o            (ld),
            .y_i            (ly),
            .busy_o         (busy[g]),
            .done_o         (done[g]),
            .pass_o         (pass[g]),
            .err_cnt_o      (errc[g]),
            .first_err_o    (ferr[g]),
            .first_err_vld_o(vld[g])
        );
        assign a[g] = 4'(la);
        assign b[g] = 4'(lb);
        assign c[g] = 4'(lc);
        assign d[g] = 4'(ld);
        assign ly   = y[g][GW-1:0];
    end

    // External AOI with fault injection
    always_comb begin
        y = '0;
        for (int g = 0; g < NDUT; g++) begin
            for (int l = 0; l < 4; l++) begin
                case (y_mode)
                    2'd0:    y[g][l] = ~((a[g][l] & b[g][l]) | (c[g][l] & d[g][l]));
                    2'd1:    y[g][l] = 1'b0;
                    2'd2:    y[g][l] = 1'b1;
                    default: y[g][l] = (a[g][l] & b[g][l]) | (c[g][l] & d[g][l]);
                endcase
                if (g == 3 && l == stuck_lane) y[g][l] = stuck_val;
            end
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int unsigned act, input int unsigned expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    // Monitor: pattern order during the first sweep, result scoreboard on done rising
    logic [NDUT-1:0] done_q = '0;
    always @(negedge clk) begin
        int unsigned off;
        exp_t        e;
        logic [3:0]  p;
        if (chk_pat && busy[1] && !arst) begin
            off = cyc - st_cyc - 1;
            if (off % 3 == 0) begin
                if (patq.size() == 0) begin
                    chk("pattern_extra", 1, 0);
                end else begin
                    p = patq.pop_front();
                    chk("pattern_order", {d[1][0], c[1][0], b[1][0], a[1][0]}, p);
                end
            end
        end
        for (int g = 0; g < NDUT; g++) begin
            if (done[g] && !done_q[g]) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = sbq.pop_front();
                    chk("done_dut", g, e.g);
                    chk("done_cycle", cyc, e.done_cyc);
                    chk("err_cnt", errc[g], e.err);
                    chk("first_err", ferr[g], e.ferr);
                    chk("first_err_vld", vld[g], e.vld);
                    chk("pass", pass[g], e.pass);
                    chk("busy_in_done", busy[g], 0);
                    chk("held_pattern", {a[g], b[g], c[g], d[g]}, {4{e.ones}});
                end
            end
        end
        done_q = done;
    end

    task automatic sweep(input int g, input logic [1:0] mode, input int sl, input logic sv,
                         input int unsigned lat, input logic [4:0] e_err, input logic [3:0] e_ferr,
                         input logic e_vld, input logic e_pass, input int gap_at,
                         input int mid_at, input bit pat);
        exp_t e;
        y_mode     = mode;
        stuck_lane = sl;
        stuck_val  = sv;
        @(negedge clk);
        start[g] = 1'b1;
        st_cyc   = cyc;
        e.g        = g;
        e.done_cyc = cyc + lat;
        e.err      = e_err;
        e.ferr     = e_ferr;
        e.vld      = e_vld;
        e.pass     = e_pass;
        e.ones     = (g == 3) ? 4'hF : 4'h1;
        sbq.push_back(e);
        if (pat) begin
            for (int i = 0; i < 16; i++) patq.push_back(4'(i));
            chk_pat = 1'b1;
        end
        for (int i = 1; i < 300; i++) begin
            @(negedge clk);
            if (i == 1) start[g] = 1'b0;
            if (i == mid_at) start[g] = 1'b1;
            if (i == mid_at + 1) start[g] = 1'b0;
            if (i == gap_at) cke = 1'b0;
            if (i == gap_at + 10) cke = 1'b1;
            if (sbq.size() == 0 && i > mid_at + 1) break;
        end
        if (sbq.size() != 0) begin
            chk("sweep_timeout", 1, 0);
            sbq.delete();
        end
        if (pat) chk("pattern_count_left", patq.size(), 0);
        chk_pat = 1'b0;
        patq.delete();
        cke = 1'b1;
        start[g] = 1'b0;
    endtask

    task automatic chk_zero(input int g, input string tag);
        chk({tag, "_busy"}, busy[g], 0);
        chk({tag, "_done"}, done[g], 0);
        chk({tag, "_pass"}, pass[g], 0);
        chk({tag, "_err_cnt"}, errc[g], 0);
        chk({tag, "_first_err"}, ferr[g], 0);
        chk({tag, "_vld"}, vld[g], 0);
        chk({tag, "_abcd"}, {a[g], b[g], c[g], d[g]}, 0);
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        chk_pat    = 1'b0;
        st_cyc     = 0;
        cke        = 1'b1;
        arst       = 1'b1;
        start      = '0;
        y_mode     = 2'd0;
        stuck_lane = -1;
        stuck_val  = 1'b0;
        repeat (3) @(negedge clk);
        for (int g = 0; g < NDUT; g++) chk_zero(g, "reset");
        arst = 1'b0;
        @(negedge clk);

        //     g  mode  sl  sv   lat err ferr vld pass gap mid pat
        sweep(1, 2'd0, -1, 0,  49,  0,  0,  0,  1, -100, 10, 1);
        sweep(1, 2'd1, -1, 0,  49,  9,  0,  1,  0, -100, -5, 0);
        sweep(1, 2'd2, -1, 0,  49,  7,  3,  1,  0, -100, -5, 0);
        sweep(1, 2'd3, -1, 0,  49, 16,  0,  1,  0, -100, -5, 0);
        sweep(1, 2'd0, -1, 0,  49,  0,  0,  0,  1, -100, -5, 0);
        sweep(0, 2'd0, -1, 0,  33,  0,  0,  0,  1, -100, -5, 0);
        sweep(0, 2'd1, -1, 0,  33,  9,  0,  1,  0, -100, -5, 0);
        sweep(2, 2'd0, -1, 0,  81,  0,  0,  0,  1, -100, -5, 0);
        sweep(2, 2'd2, -1, 0,  81,  7,  3,  1,  0, -100, -5, 0);
        sweep(1, 2'd0, -1, 0,  59,  0,  0,  0,  1,   15, -5, 0);
        sweep(3, 2'd0, -1, 0,  49,  0,  0,  0,  1, -100, -5, 0);
        // a lane stuck at 0 misses every pattern where the AOI should give 1
        sweep(3, 2'd0,  2, 0,  49,  9,  0,  1,  0, -100, -5, 0);
        sweep(3, 2'd0,  1, 1,  49,  7,  3,  1,  0, -100, -5, 0);

        // Abort a failing sweep with an async reset at cycle 20
        y_mode = 2'd1;
        stuck_lane = -1;
        @(negedge clk);
        start[1] = 1'b1;
        @(negedge clk);
        start[1] = 1'b0;
        repeat (19) @(negedge clk);
        chk("busy_before_abort", busy[1], 1);
        chk("err_before_abort_nonzero", (errc[1] != 0), 1);
        arst = 1'b1;
        #1;
        chk_zero(1, "abort");
        @(negedge clk);
        arst = 1'b0;
        repeat (5) @(negedge clk);
        chk_zero(1, "idle_after_abort");

        sweep(1, 2'd0, -1, 0,  49,  0,  0,  0,  1, -100, -5, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
